// File: rtl/imem_arbiter.sv
// Two-requester arbiter for the instruction memory read port with a hold limit.
// Optional grant/conflict counters are enabled by defining IMEM_ARB_STATS_EN.
module imem_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int BUS_WIDTH  = 10,
  parameter int MAX_HOLD   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  m0_req,
  input  logic [31:0]           m0_addr,
  output logic                  m0_gnt,
  output logic                  m0_rvalid,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  output logic                  m0_err,
  input  logic                  m1_req,
  input  logic [31:0]           m1_addr,
  output logic                  m1_gnt,
  output logic                  m1_rvalid,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  m1_err,
  output logic [BUS_WIDTH-1:0]  mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata
`ifdef IMEM_ARB_STATS_EN
  ,
  output logic [31:0]           stat_gnt0,
  output logic [31:0]           stat_gnt1,
  output logic [31:0]           stat_conflict
`endif
);

  localparam int HW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);

  logic          last_gnt_q, last_gnt_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic          m0_rvalid_q, m1_rvalid_q;
  logic          m0_err_q, m1_err_q;
  logic [DATA_WIDTH-1:0] m0_rdata_q, m1_rdata_q;
  logic          winner;
  logic          unused_addr;

  // Only the word-address bits reach the memory; the rest wrap away.
  assign unused_addr = ^{m0_addr[31:BUS_WIDTH+2], m1_addr[31:BUS_WIDTH+2]};

  always_comb begin
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    winner = last_gnt_q;
    if (rst_n) begin
      if (m0_req && m1_req) begin
        winner = (hold_cnt_q < HOLD_MAX) ? last_gnt_q : ~last_gnt_q;
        m0_gnt = ~winner;
        m1_gnt = winner;
      end else begin
        m0_gnt = m0_req;
        m1_gnt = m1_req;
      end
    end
  end

  always_comb begin
    mem_addr = '0;
    if (m0_gnt)      mem_addr = m0_addr[BUS_WIDTH+1:2];
    else if (m1_gnt) mem_addr = m1_addr[BUS_WIDTH+1:2];
  end

  always_comb begin
    last_gnt_d = last_gnt_q;
    hold_cnt_d = hold_cnt_q;
    if (m0_gnt || m1_gnt) begin
      if (m1_gnt == last_gnt_q) begin
        if (hold_cnt_q < HOLD_MAX) hold_cnt_d = hold_cnt_q + HW'(1);
      end else begin
        last_gnt_d = m1_gnt;
        hold_cnt_d = HW'(1);
      end
    end else begin
      hold_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt_q  <= 1'b0;
      hold_cnt_q  <= '0;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
      m0_err_q    <= 1'b0;
      m1_err_q    <= 1'b0;
    end else begin
      last_gnt_q  <= last_gnt_d;
      hold_cnt_q  <= hold_cnt_d;
      m0_rvalid_q <= m0_gnt;
      m1_rvalid_q <= m1_gnt;
      // Losers keep their previous data so a slow consumer can still read it.
      if (m0_gnt) begin
        m0_rdata_q <= mem_rdata;
        m0_err_q   <= (m0_addr[1:0] != 2'b00);
      end
      if (m1_gnt) begin
        m1_rdata_q <= mem_rdata;
        m1_err_q   <= (m1_addr[1:0] != 2'b00);
      end
    end
  end

  assign m0_rvalid = m0_rvalid_q;
  assign m1_rvalid = m1_rvalid_q;
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;
  assign m0_err    = m0_err_q;
  assign m1_err    = m1_err_q;

`ifdef IMEM_ARB_STATS_EN
  logic [31:0] stat_gnt0_q, stat_gnt1_q, stat_conflict_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_gnt0_q     <= '0;
      stat_gnt1_q     <= '0;
      stat_conflict_q <= '0;
    end else begin
      if (m0_gnt)            stat_gnt0_q     <= stat_gnt0_q + 32'd1;
      if (m1_gnt)            stat_gnt1_q     <= stat_gnt1_q + 32'd1;
      if (m0_req && m1_req)  stat_conflict_q <= stat_conflict_q + 32'd1;
    end
  end

  assign stat_gnt0     = stat_gnt0_q;
  assign stat_gnt1     = stat_gnt1_q;
  assign stat_conflict = stat_conflict_q;
`endif

endmodule

// File: tb/tb_imem_arbiter.sv
// Self-checking bench for imem_arbiter: directed scenarios plus randomized traffic
// checked against a run-length arbitration model and an array model of the imem.
module tb_imem_arbiter;

  localparam int DW = 32;
  localparam int BW = 10;
  localparam int MH = 4;

  logic          clk = 1'b0;
  logic          rstN;
  logic          m0Req, m1Req;
  logic [31:0]   m0Addr, m1Addr;
  logic          m0Gnt, m1Gnt, m0Rvalid, m1Rvalid, m0Err, m1Err;
  logic [DW-1:0] m0Rdata, m1Rdata;
  logic [BW-1:0] memAddr;
  logic [DW-1:0] memRdata;
`ifdef IMEM_ARB_STATS_EN
  logic [31:0]   statGnt0, statGnt1, statConflict;
`endif

  logic [DW-1:0] mem [1 << BW];

  int checks = 0;
  int errors = 0;

  // Reference model state: who won last and how many grants in a row it has had.
  bit lastWin;
  int runLen;
  int cntG0, cntG1, cntConf;

  bit            expG0, expG1, expRv0, expRv1, expErr0, expErr1;
  logic [BW-1:0] expAddr;
  logic [DW-1:0] expRd0, expRd1;
  bit            obsG0, obsG1, obsRv0, obsRv1, obsErr0, obsErr1;
  logic [BW-1:0] obsAddr;
  logic [DW-1:0] obsRd0, obsRd1;

  always #5 clk = ~clk;

  assign memRdata = mem[memAddr];

  imem_arbiter #(.DATA_WIDTH(DW), .BUS_WIDTH(BW), .MAX_HOLD(MH)) dut (
    .clk(clk), .rst_n(rstN),
    .m0_req(m0Req), .m0_addr(m0Addr), .m0_gnt(m0Gnt), .m0_rvalid(m0Rvalid),
    .m0_rdata(m0Rdata), .m0_err(m0Err),
    .m1_req(m1Req), .m1_addr(m1Addr), .m1_gnt(m1Gnt), .m1_rvalid(m1Rvalid),
    .m1_rdata(m1Rdata), .m1_err(m1Err),
    .mem_addr(memAddr), .mem_rdata(memRdata)
`ifdef IMEM_ARB_STATS_EN
    , .stat_gnt0(statGnt0), .stat_gnt1(statGnt1), .stat_conflict(statConflict)
`endif
  );

  task automatic modelReset();
    lastWin = 1'b0;
    runLen  = 0;
    cntG0 = 0; cntG1 = 0; cntConf = 0;
    expRd0 = '0; expRd1 = '0; expErr0 = 1'b0; expErr1 = 1'b0;
  endtask

  task automatic modelGrant(input bit r0, input bit r1, output bit g0, output bit g1);
    bit w;
    if (r0 && r1) begin
      w  = (runLen < MH) ? lastWin : !lastWin;
      g0 = !w;
      g1 = w;
    end else begin
      g0 = r0;
      g1 = r1;
    end
  endtask

  task automatic modelCommit(input bit g0, input bit g1);
    if (!g0 && !g1) runLen = 0;
    else if (g1 == lastWin) runLen++;
    else begin
      lastWin = g1;
      runLen  = 1;
    end
  endtask

  // Drives one cycle of requests, records the DUT's grant and response, and
  // advances the model so the caller can compare both.
  task automatic applyStimulus(input bit r0, input logic [31:0] a0,
                               input bit r1, input logic [31:0] a1);
    @(negedge clk);
    m0Req = r0; m0Addr = a0; m1Req = r1; m1Addr = a1;
    #1;
    modelGrant(r0, r1, expG0, expG1);
    expAddr = expG0 ? a0[BW+1:2] : (expG1 ? a1[BW+1:2] : '0);
    obsG0 = m0Gnt; obsG1 = m1Gnt; obsAddr = memAddr;
    @(posedge clk);
    modelCommit(expG0, expG1);
    cntG0 += int'(expG0);
    cntG1 += int'(expG1);
    cntConf += int'(r0 && r1);
    expRv0 = expG0;
    expRv1 = expG1;
    if (expG0) begin expRd0 = mem[a0[BW+1:2]]; expErr0 = (a0[1:0] != 2'b00); end
    if (expG1) begin expRd1 = mem[a1[BW+1:2]]; expErr1 = (a1[1:0] != 2'b00); end
    #1;
    obsRv0 = m0Rvalid; obsRv1 = m1Rvalid; obsRd0 = m0Rdata; obsRd1 = m1Rdata;
    obsErr0 = m0Err; obsErr1 = m1Err;
  endtask

  task automatic applyReset();
    @(negedge clk);
    rstN = 1'b0; m0Req = 1'b0; m1Req = 1'b0;
    @(negedge clk);
    rstN = 1'b1;
    modelReset();
  endtask

  task automatic test_reset();
    rstN = 1'b0; m0Req = 1'b1; m1Req = 1'b1; m0Addr = 32'h10; m1Addr = 32'h20;
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if ({m0Gnt, m1Gnt, m0Rvalid, m1Rvalid, memAddr} !== {4'b0000, {BW{1'b0}}}) begin
      errors++;
      $display("[TB] FAIL reset_outputs gnt=%b%b rvalid=%b%b mem_addr=%h required all zero",
               m0Gnt, m1Gnt, m0Rvalid, m1Rvalid, memAddr);
    end
    checks++;
    if ({m0Rdata, m1Rdata, m0Err, m1Err} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_data rdata0=%h rdata1=%h err=%b%b required zero",
               m0Rdata, m1Rdata, m0Err, m1Err);
    end
    @(negedge clk);
    rstN = 1'b1;
    #1;
    checks++;
    if ({m0Gnt, m1Gnt, memAddr} !== {2'b10, BW'(4)}) begin
      errors++;
      $display("[TB] FAIL reset_first_winner gnt=%b%b mem_addr=%h required gnt=10 mem_addr=004",
               m0Gnt, m1Gnt, memAddr);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({m0Rvalid, m1Rvalid, m0Rdata} !== {2'b10, mem[4]}) begin
      errors++;
      $display("[TB] FAIL reset_first_resp rvalid=%b%b rdata=%h required 10 %h",
               m0Rvalid, m1Rvalid, m0Rdata, mem[4]);
    end
  endtask

  task automatic test_single();
    applyReset();
    applyStimulus(1'b1, 32'h2c, 1'b0, 32'h0);
    checks++;
    if ({obsG0, obsG1, obsAddr} !== {2'b10, BW'(11)}) begin
      errors++;
      $display("[TB] FAIL single_grant gnt=%b%b mem_addr=%h required 10 00b", obsG0, obsG1, obsAddr);
    end
    checks++;
    if ({obsRv0, obsRv1, obsRd0, obsErr0} !== {2'b10, mem[11], 1'b0}) begin
      errors++;
      $display("[TB] FAIL single_resp rvalid=%b%b rdata=%h err=%b required 10 %h 0",
               obsRv0, obsRv1, obsRd0, obsErr0, mem[11]);
    end
    // Back-to-back fetches from one requester: one word every cycle.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 32'h100 + 32'(4 * i), 1'b0, 32'h0);
      checks++;
      if ({obsG0, obsAddr, obsRv0, obsRd0} !== {1'b1, expAddr, 1'b1, expRd0}) begin
        errors++;
        $display("[TB] FAIL back_to_back[%0d] gnt=%b addr=%h rvalid=%b rdata=%h required 1 %h 1 %h",
                 i, obsG0, obsAddr, obsRv0, obsRd0, expAddr, expRd0);
      end
    end
  endtask

  task automatic test_hold();
    logic [8:0] pattern;
    pattern = 9'b011110000;
    applyReset();
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1'b1, $urandom, 1'b1, $urandom);
      checks++;
      if ({obsG0, obsG1} !== {!pattern[i], pattern[i]} || obsAddr !== expAddr) begin
        errors++;
        $display("[TB] FAIL hold_seq[%0d] gnt=%b%b addr=%h required %b%b %h",
                 i, obsG0, obsG1, obsAddr, !pattern[i], pattern[i], expAddr);
      end
    end
  endtask

  task automatic test_idle();
    applyReset();
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, $urandom, 1'b0, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, $urandom, 1'b1, $urandom);
      checks++;
      if ({obsG0, obsG1} !== ((i < 4) ? 2'b10 : 2'b01)) begin
        errors++;
        $display("[TB] FAIL idle_reset[%0d] gnt=%b%b required %b", i, obsG0, obsG1,
                 (i < 4) ? 2'b10 : 2'b01);
      end
    end
  endtask

  task automatic test_misaligned();
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h42);
    checks++;
    if ({obsG1, obsAddr} !== {1'b1, BW'(16)}) begin
      errors++;
      $display("[TB] FAIL misaligned_addr gnt1=%b mem_addr=%h required 1 010", obsG1, obsAddr);
    end
    checks++;
    if ({obsRv0, obsRv1, obsErr1, obsRd1} !== {3'b011, mem[16]}) begin
      errors++;
      $display("[TB] FAIL misaligned_resp rvalid=%b%b err1=%b rdata1=%h required 01 1 %h",
               obsRv0, obsRv1, obsErr1, obsRd1, mem[16]);
    end
  endtask

  task automatic test_random();
    bit p0, p1;
    logic [31:0] a0, a1;
    p0 = 1'b0; p1 = 1'b0; a0 = '0; a1 = '0;
    for (int i = 0; i < 400; i++) begin
      if (!p0 && $urandom_range(0, 3) != 0) begin p0 = 1'b1; a0 = $urandom; end
      if (!p1 && $urandom_range(0, 3) != 0) begin p1 = 1'b1; a1 = $urandom; end
      if (p0 && $urandom_range(0, 15) == 0) p0 = 1'b0;
      if (p1 && $urandom_range(0, 15) == 0) p1 = 1'b0;
      applyStimulus(p0, a0, p1, a1);
      checks++;
      if ({obsG0, obsG1, obsAddr} !== {expG0, expG1, expAddr}) begin
        errors++;
        $display("[TB] FAIL rand_grant[%0d] gnt=%b%b addr=%h required %b%b %h",
                 i, obsG0, obsG1, obsAddr, expG0, expG1, expAddr);
      end
      checks++;
      if ({obsRv0, obsRv1, obsRd0, obsRd1, obsErr0 & obsRv0, obsErr1 & obsRv1} !==
          {expRv0, expRv1, expRd0, expRd1, expErr0 & expRv0, expErr1 & expRv1}) begin
        errors++;
        $display("[TB] FAIL rand_resp[%0d] rv=%b%b rd=%h/%h err=%b%b required %b%b %h/%h %b%b",
                 i, obsRv0, obsRv1, obsRd0, obsRd1, obsErr0, obsErr1,
                 expRv0, expRv1, expRd0, expRd1, expErr0, expErr1);
      end
      if (expG0) p0 = 1'b0;
      if (expG1) p1 = 1'b0;
    end
`ifdef IMEM_ARB_STATS_EN
    checks++;
    if ({statGnt0, statGnt1, statConflict} !== {32'(cntG0), 32'(cntG1), 32'(cntConf)}) begin
      errors++;
      $display("[TB] FAIL stats g0=%0d g1=%0d conf=%0d required %0d %0d %0d",
               statGnt0, statGnt1, statConflict, cntG0, cntG1, cntConf);
    end
`endif
  endtask

  task automatic test_midreset();
    applyReset();
    @(negedge clk);
    m0Req = 1'b1; m0Addr = 32'h4; m1Req = 1'b0;
    #1;
    checks++;
    if ({m0Gnt, memAddr} !== {1'b1, BW'(1)}) begin
      errors++;
      $display("[TB] FAIL midreset_grant gnt0=%b addr=%h required 1 001", m0Gnt, memAddr);
    end
    #2;
    rstN = 1'b0;
    #1;
    m0Req = 1'b0;
    checks++;
    if ({m0Gnt, m1Gnt, memAddr} !== '0) begin
      errors++;
      $display("[TB] FAIL midreset_gnt_forced gnt=%b%b addr=%h required zero", m0Gnt, m1Gnt, memAddr);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({m0Rvalid, m1Rvalid} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL midreset_rvalid rvalid=%b%b required 00", m0Rvalid, m1Rvalid);
    end
`ifdef IMEM_ARB_STATS_EN
    checks++;
    if ({statGnt0, statGnt1, statConflict} !== '0) begin
      errors++;
      $display("[TB] FAIL midreset_stats g0=%0d g1=%0d conf=%0d required 0 0 0",
               statGnt0, statGnt1, statConflict);
    end
`endif
    @(negedge clk);
    rstN = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({m0Rvalid, m1Rvalid} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL midreset_after rvalid=%b%b required 00", m0Rvalid, m1Rvalid);
    end
    modelReset();
  endtask

  initial begin
    for (int i = 0; i < (1 << BW); i++) mem[i] = $urandom;
    m0Req = 1'b0; m1Req = 1'b0; m0Addr = '0; m1Addr = '0; rstN = 1'b0;
    modelReset();
    test_reset();
    test_single();
    test_hold();
    test_idle();
    test_misaligned();
    test_random();
    test_midreset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

endmodule
